// File: rtl/stl_rr_arb_pkg.sv
// Shared types and helpers for the round-robin packet-lock arbiter.
package stl_rr_arb_pkg;

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_st_e;

  // Upper bound on requester count for the one-hot helper; callers slice the low bits.
  localparam int MAX_REQ = 64;

  // Index width, never below one bit so the NUM_REQ=1 build still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] idx2onehot(input int idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/stl_rr_prio_pick.sv
// Round-robin find-first: lowest set request at or above ptr, wrapping.
module stl_rr_prio_pick
  import stl_rr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [2*N-1:0] ONE = (2*N)'(1);

  logic [2*N-1:0]     dbl, mask, hit;
  logic [MAX_REQ-1:0] oh_full;

  // The doubled vector turns the wrap into a plain linear search from ptr.
  always_comb begin
    dbl  = {req, req};
    mask = ~((ONE << ptr) - ONE);
    hit  = dbl & mask;
    any  = |req;
    idx  = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (hit[i]) idx = IW'(i % N);
    end
    oh_full = idx2onehot(int'(idx));
    onehot  = any ? oh_full[N-1:0] : '0;
  end

endmodule

// File: rtl/stl_rr_arb_lock.sv
// N-input round-robin arbiter with packet lock and one registered output stage.
// Optional STL_RR_ARB_ERR_EN adds a sticky err_o grant-consistency monitor.
module stl_rr_arb_lock
  import stl_rr_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_vld_i,
  output logic [NUM_REQ-1:0]        req_rdy_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_last_o,
  output logic [NUM_REQ-1:0]        out_gnt_o,
  output logic [IDX_W-1:0]          out_idx_o
`ifdef STL_RR_ARB_ERR_EN
  ,
  output logic                      err_o
`endif
);

  logic                load_en, acc, win_any, win_last, pk_any;
  logic [NUM_REQ-1:0]  pk_oh, sel, gnt_q;
  logic [IDX_W-1:0]    pk_idx, win_idx, ptr, ptr_nxt, lock_idx, lock_nxt;
  logic [MAX_REQ-1:0]  lock_oh;
  arb_st_e             state, state_nxt;

  assign load_en = ~out_vld_o | out_rdy_i;

  stl_rr_prio_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req    (req_vld_i),
    .ptr    (ptr),
    .onehot (pk_oh),
    .idx    (pk_idx),
    .any    (pk_any)
  );

  // While locked only the owner may win; others stay blocked even if it idles.
  always_comb begin
    lock_oh = idx2onehot(int'(lock_idx));
    win_idx = pk_idx;
    sel     = pk_oh;
    win_any = pk_any;
    if (state == LOCKED) begin
      win_idx = lock_idx;
      sel     = lock_oh[NUM_REQ-1:0] & req_vld_i;
      win_any = |sel;
    end
  end

  assign win_last  = req_last_i[win_idx];
  assign acc       = load_en & win_any;
  assign req_rdy_o = load_en ? sel : '0;

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_idx;
    ptr_nxt   = ptr;
    if (acc) begin
      if (win_last) begin
        state_nxt = ARB;
        ptr_nxt   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
      end else begin
        state_nxt = LOCKED;
        lock_nxt  = win_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ARB;
      ptr      <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_idx <= lock_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_o  <= 1'b0;
      out_data_o <= '0;
      out_last_o <= 1'b0;
      gnt_q      <= '0;
      out_idx_o  <= '0;
    end else if (load_en) begin
      out_vld_o <= acc;
      if (acc) begin
        out_data_o <= req_data_i[win_idx*DATA_W +: DATA_W];
        out_last_o <= win_last;
        gnt_q      <= sel;
        out_idx_o  <= win_idx;
      end
    end
  end

  // An empty load may leave stale grant bits behind; hide them when idle.
  assign out_gnt_o = out_vld_o ? gnt_q : '0;

`ifdef STL_RR_ARB_ERR_EN
  logic [MAX_REQ-1:0] idx_oh;
  logic               err_now, gnt_not_oh, rdy_multi;

  always_comb begin
    idx_oh     = idx2onehot(int'(out_idx_o));
    gnt_not_oh = (out_gnt_o == '0) || ((out_gnt_o & (out_gnt_o - NUM_REQ'(1))) != '0);
    rdy_multi  = (req_rdy_o & (req_rdy_o - NUM_REQ'(1))) != '0;
    err_now    = (out_vld_o & gnt_not_oh)
               | (out_vld_o & (out_gnt_o != idx_oh[NUM_REQ-1:0]))
               | rdy_multi;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_o <= 1'b0;
    else       err_o <= err_o | err_now;
  end
`endif

endmodule

// File: tb/tb_stl_rr_arb_lock.sv
// Self-checking bench: directed cases with literal expectations, then random traffic vs a reference model.
module tb_stl_rr_arb_lock;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_vld_i, req_rdy_o, req_last_i, out_gnt_o;
  logic [N*DW-1:0] req_data_i;
  logic            out_vld_o, out_rdy_i, out_last_o;
  logic [DW-1:0]   out_data_o;
  logic [IW-1:0]   out_idx_o;
`ifdef STL_RR_ARB_ERR_EN
  logic            err_o;
`endif

  logic [DW-1:0] dat [N];
  int n_chk = 0, n_err = 0;

  // reference model state
  bit            m_known = 0, m_vld = 0, m_last = 0, m_locked = 0;
  logic [DW-1:0] m_data = '0;
  int            m_idx = 0, m_ptr = 0, m_lock = 0;
  logic [N-1:0]  acc_mask;
  int            log_q[$];

  stl_rr_arb_lock #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_gnt_o(out_gnt_o), .out_idx_o(out_idx_o)
`ifdef STL_RR_ARB_ERR_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data_i[g*DW +: DW] = dat[g];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: compare against the model at negedge, advance model, return at posedge+1.
  task automatic tick();
    int win;
    bit le;
    logic [N-1:0] er;
    @(negedge clk_i);
    acc_mask = req_rdy_o;
    if (m_known) begin
      le  = !m_vld || out_rdy_i;
      win = -1;
      if (m_locked) begin
        if (req_vld_i[m_lock]) win = m_lock;
      end else begin
        for (int j = 0; j < N; j++)
          if (win < 0 && req_vld_i[(m_ptr + j) % N]) win = (m_ptr + j) % N;
      end
      er = (le && win >= 0) ? (N'(1) << win) : '0;
      chk("req_rdy", req_rdy_o, er);
      chk("out_vld", out_vld_o, m_vld);
      if (m_vld) begin
        chk("out_data", out_data_o, m_data);
        chk("out_last", out_last_o, m_last);
        chk("out_idx", out_idx_o, m_idx);
        chk("out_gnt", out_gnt_o, N'(1) << m_idx);
      end else begin
        chk("out_gnt_idle", out_gnt_o, 0);
      end
`ifdef STL_RR_ARB_ERR_EN
      chk("err", err_o, 0);
`endif
      if (out_vld_o && out_rdy_i) log_q.push_back(int'(out_idx_o));
      if (!rst_i && le) begin
        m_vld = (win >= 0);
        if (win >= 0) begin
          m_data = dat[win];
          m_last = req_last_i[win];
          m_idx  = win;
          if (req_last_i[win]) begin
            m_locked = 0;
            m_ptr    = (win + 1) % N;
          end else begin
            m_locked = 1;
            m_lock   = win;
          end
        end
      end
    end
    if (rst_i) begin
      m_known = 1; m_vld = 0; m_ptr = 0; m_locked = 0; m_lock = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    req_vld_i = v; req_last_i = l; out_rdy_i = r;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; drive('0, '0, 1'b1);
    tick(); tick();
    rst_i = 1'b0;
    log_q.delete();
  endtask

  task automatic chk_log(input string nm, input int exp[8], input int n);
    chk({nm, "_beats"}, log_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < log_q.size()) chk($sformatf("%s_idx%0d", nm, i), log_q[i], exp[i]);
  endtask

  initial begin
    bit pend [N];
    int e1[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    int e2[8] = '{0, 1, 2, 2, 2, 3, 0, 0};
    int e4[8] = '{3, 3, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < N; k++) dat[k] = DW'(8'h10 + k);
    do_reset();

    // reset state
    #1;
    chk("rst_vld", out_vld_o, 0); chk("rst_gnt", out_gnt_o, 0); chk("rst_idx", out_idx_o, 0);
    chk("rst_data", out_data_o, 0); chk("rst_last", out_last_o, 0); chk("rst_rdy", req_rdy_o, 0);

    // all valid, single-beat packets: strict rotation
    for (int c = 0; c < 5; c++) begin drive(4'b1111, 4'b1111, 1'b1); tick(); end
    drive('0, '0, 1'b1); tick(); tick();
    chk_log("rot", e1, 5);

    // 3-beat packet from requester 2 with ptr at 2
    do_reset();
    for (int k = 0; k < N; k++) dat[k] = DW'(8'h20 + k);
    drive(4'b0011, 4'b1111, 1'b1); tick(); tick();
    drive(4'b1111, 4'b1011, 1'b1); tick(); tick();
    drive(4'b1111, 4'b1111, 1'b1); tick(); tick(); tick();
    drive('0, '0, 1'b1); tick(); tick();
    chk_log("pkt", e2, 7);

    // output held under backpressure
    do_reset();
    dat[1] = 8'hA5;
    drive(4'b0010, 4'b1111, 1'b1); tick();
    for (int c = 0; c < 5; c++) begin
      drive(4'b1101, 4'b1111, 1'b0); #1;
      chk("hold_data", out_data_o, 8'hA5);
      chk("hold_gnt", out_gnt_o, 4'b0010);
      chk("hold_rdy", req_rdy_o, 0);
      tick();
    end
    drive(4'b1101, 4'b1111, 1'b1); #1;
    chk("release_rdy", req_rdy_o, 4'b0100);
    tick();
    chk("release_idx", out_idx_o, 2);
    drive('0, '0, 1'b1); tick(); tick();

    // locked requester 3 goes idle mid-packet
    do_reset();
    drive(4'b1000, 4'b0000, 1'b1); #1; chk("lk_first", req_rdy_o, 4'b1000); tick();
    drive(4'b0001, 4'b1111, 1'b1); #1; chk("lk_block", req_rdy_o, 0); tick();
    #1; chk("lk_empty_vld", out_vld_o, 0); chk("lk_block2", req_rdy_o, 0); tick();
    drive(4'b1001, 4'b1111, 1'b1); #1; chk("lk_resume", req_rdy_o, 4'b1000); tick();
    drive(4'b0001, 4'b1111, 1'b1); #1; chk("lk_next", req_rdy_o, 4'b0001); tick();
    drive('0, '0, 1'b1); tick(); tick();
    chk_log("lk", e4, 3);

    // reset while locked with a beat in the output register
    do_reset();
    drive(4'b0010, 4'b0000, 1'b1); tick();
    rst_i = 1'b1; drive('0, '0, 1'b0); tick();
    rst_i = 1'b0; #1;
    chk("mrst_vld", out_vld_o, 0); chk("mrst_gnt", out_gnt_o, 0);
    drive(4'b0101, 4'b1111, 1'b1); #1;
    chk("mrst_ptr0", req_rdy_o, 4'b0001);
    tick();
    drive('0, '0, 1'b1); tick(); tick();

    // random traffic honouring the upstream hold rule
    do_reset();
    for (int k = 0; k < N; k++) pend[k] = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < N; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1; dat[k] = DW'($urandom); req_last_i[k] = 1'($urandom_range(0, 1));
        end
      for (int k = 0; k < N; k++) req_vld_i[k] = pend[k];
      out_rdy_i = ($urandom_range(0, 3) != 0);
      rst_i = ($urandom_range(0, 199) == 0);
      tick();
      for (int k = 0; k < N; k++) if (acc_mask[k]) pend[k] = 0;
    end
    rst_i = 1'b0;
    drive('0, '0, 1'b1); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
